// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU issue front end and the
// ALUOp/funct control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_control_decoder.sv
// Combinational ALUOp/funct3/funct7b5 to ALUControl decoder, shared with the
// single-cycle control path. Macro ALU_ISSUE_ILLEGAL_EN selects NOP for illegal codes.
module alu_control_decoder
  import alu_pkg::*;
(
  input  logic [1:0] reqAluOp,
  input  logic [2:0] reqFunct3,
  input  logic       reqFunct7b5,
  output logic [3:0] ALUControl,
  output logic       illegal
);

  logic [3:0] w_ctrl;

  always_comb begin
    w_ctrl  = ALU_ADD;
    illegal = 1'b0;
    case (reqAluOp)
      ALUOP_MEM: w_ctrl = ALU_ADD;
      ALUOP_BR:  w_ctrl = ALU_SUB;
      ALUOP_R: begin
        case (reqFunct3)
          3'b000:  w_ctrl = reqFunct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  w_ctrl = ALU_AND;
          3'b110:  w_ctrl = ALU_OR;
          3'b010: begin
            if (reqFunct7b5) illegal = 1'b1;
            else             w_ctrl  = ALU_SLT;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal codes either force a NOP (ALU returns zero) or fall through as add.
  always_comb begin
    ALUControl = w_ctrl;
    if (illegal) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
      ALUControl = ALU_NOP;
`else
      ALUControl = ALU_ADD;
`endif
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Sequential front end for the external combinational ALU: request handshake,
// decode, registered operands, captured response. Macro ALU_ISSUE_ILLEGAL_EN adds rspIllegal.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [1:0]           reqAluOp,
  input  logic [2:0]           reqFunct3,
  input  logic                 reqFunct7b5,
  input  logic [WIDTH-1:0]     reqA,
  input  logic [WIDTH-1:0]     reqB,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [3:0]           ALUControl,
  input  logic [WIDTH-1:0]     result,
  input  logic                 carryOut,
  input  logic                 zero,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [WIDTH-1:0]     rspResult,
  output logic                 rspCarry,
  output logic                 rspZero,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic                 rspIllegal,
`endif
  output logic [CNT_WIDTH-1:0] issueCount,
  output alu_state_e           dbgState
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // reqReady is high in IDLE, and in HOLD only while rspReady is high, so a
  // response drain and the next accept can share one edge.

  alu_state_e           r_state;
  alu_state_e           w_next_state;
  logic                 w_accept;
  logic [3:0]           w_ctrl;
  logic                 w_illegal;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [3:0]           r_ctrl;
  logic [WIDTH-1:0]     r_rsp_result;
  logic                 r_rsp_carry;
  logic                 r_rsp_zero;
  logic [CNT_WIDTH-1:0] r_cnt;

  alu_control_decoder u_dec (
    .reqAluOp    (reqAluOp),
    .reqFunct3   (reqFunct3),
    .reqFunct7b5 (reqFunct7b5),
    .ALUControl  (w_ctrl),
    .illegal     (w_illegal)
  );

  assign reqReady = (r_state == IDLE) || ((r_state == HOLD) && rspReady);
  assign w_accept = reqValid && reqReady;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (reqValid) w_next_state = ISSUE;
      ISSUE:   w_next_state = HOLD;
      HOLD:    if (rspReady) w_next_state = reqValid ? ISSUE : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_ctrl       <= ALU_AND;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a    <= reqA;
        r_b    <= reqB;
        r_ctrl <= w_ctrl;
        r_cnt  <= r_cnt + 1'b1;
      end
      // The ALU has had the whole ISSUE cycle to settle on the registered inputs.
      if (r_state == ISSUE) begin
        r_rsp_result <= result;
        r_rsp_carry  <= carryOut;
        r_rsp_zero   <= zero;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic r_illegal;
  logic r_rsp_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal     <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else begin
      if (w_accept)           r_illegal     <= w_illegal;
      if (r_state == ISSUE)   r_rsp_illegal <= r_illegal;
    end
  end

  assign rspIllegal = r_rsp_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_illegal;
`endif

  assign a          = r_a;
  assign b          = r_b;
  assign ALUControl = r_ctrl;
  assign rspValid   = (r_state == HOLD);
  assign rspResult  = r_rsp_result;
  assign rspCarry   = r_rsp_carry;
  assign rspZero    = r_rsp_zero;
  assign issueCount = r_cnt;
  assign dbgState   = r_state;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural 64-bit ALU attached;
// honours ALU_ISSUE_ILLEGAL_EN for the illegal-decode expectations.
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int W  = 64;
  localparam int CW = 4;
`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [1:0]    reqAluOp = 2'b00;
  logic [2:0]    reqFunct3 = 3'b000;
  logic          reqFunct7b5 = 1'b0;
  logic [W-1:0]  reqA = '0;
  logic [W-1:0]  reqB = '0;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    ALUControl;
  logic [W-1:0]  result;
  logic          carryOut;
  logic          zero;
  logic          rspValid;
  logic          rspReady = 1'b1;
  logic [W-1:0]  rspResult;
  logic          rspCarry;
  logic          rspZero;
  logic [CW-1:0] issueCount;
  alu_state_e    dbgState;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic          rspIllegal;
`endif

  alu_issue_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqAluOp    (reqAluOp),
    .reqFunct3   (reqFunct3),
    .reqFunct7b5 (reqFunct7b5),
    .reqA        (reqA),
    .reqB        (reqB),
    .a           (a),
    .b           (b),
    .ALUControl  (ALUControl),
    .result      (result),
    .carryOut    (carryOut),
    .zero        (zero),
    .rspValid    (rspValid),
    .rspReady    (rspReady),
    .rspResult   (rspResult),
    .rspCarry    (rspCarry),
    .rspZero     (rspZero),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .rspIllegal  (rspIllegal),
`endif
    .issueCount  (issueCount),
    .dbgState    (dbgState)
  );

  // Behavioural combinational ALU; sub carry is the carry-out of a + ~b + 1.
  always_comb begin
    result   = '0;
    carryOut = 1'b0;
    case (ALUControl)
      4'b0010: {carryOut, result} = {1'b0, a} + {1'b0, b};
      4'b0110: {carryOut, result} = {1'b0, a} + {1'b0, ~b} + 65'd1;
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0111: result = {{(W-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
    zero = (result == '0);
  end

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [3:0]  ctrl;
    logic [W-1:0] res;
    logic        carry;
    logic        zf;
    logic        ill;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic drive_req(input vec_t v);
    reqAluOp    = v.aluop;
    reqFunct3   = v.f3;
    reqFunct7b5 = v.f7;
    reqA        = v.opa;
    reqB        = v.opb;
    reqValid    = 1'b1;
  endtask

  // Entered and left at posedge+1 with the unit in IDLE and rspReady high.
  task automatic run_op(input vec_t v);
    int n;
    logic [W-1:0] e;
    drive_req(v);
    n = 0;
    while (!reqReady && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({v.name, "_ready_wait"}, 64'(reqReady), 64'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    exp_cnt++;
    exp_q.push_back(v.res);
    check({v.name, "_state_issue"}, 64'(dbgState), 64'(ISSUE));
    check({v.name, "_ctrl"}, 64'(ALUControl), 64'(v.ctrl));
    check({v.name, "_opa"}, a, v.opa);
    check({v.name, "_opb"}, b, v.opb);
    check({v.name, "_rspvalid_issue"}, 64'(rspValid), 64'd0);
    check({v.name, "_count"}, 64'(issueCount), 64'(exp_cnt));
    @(posedge clk); #1;
    check({v.name, "_rspvalid"}, 64'(rspValid), 64'd1);
    e = exp_q.pop_front();
    check({v.name, "_result"}, rspResult, e);
    check({v.name, "_carry"}, 64'(rspCarry), 64'(v.carry));
    check({v.name, "_zero"}, 64'(rspZero), 64'(v.zf));
`ifdef ALU_ISSUE_ILLEGAL_EN
    check({v.name, "_illegal"}, 64'(rspIllegal), 64'(v.ill));
`endif
    @(posedge clk); #1;
    check({v.name, "_back_idle"}, 64'(dbgState), 64'(IDLE));
    check({v.name, "_ctrl_held"}, 64'(ALUControl), 64'(v.ctrl));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(dbgState), 64'(IDLE));
    check({tag, "_rspvalid"}, 64'(rspValid), 64'd0);
    check({tag, "_rspresult"}, rspResult, 64'd0);
    check({tag, "_rspcarry"}, 64'(rspCarry), 64'd0);
    check({tag, "_rspzero"}, 64'(rspZero), 64'd0);
    check({tag, "_a"}, a, 64'd0);
    check({tag, "_b"}, b, 64'd0);
    check({tag, "_ctrl"}, 64'(ALUControl), 64'd0);
    check({tag, "_count"}, 64'(issueCount), 64'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check({tag, "_illegal"}, 64'(rspIllegal), 64'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  vec_t vecs[11];
  vec_t v;

  initial begin
    vecs[0]  = '{"r_add_carry", 2'b10, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                 4'b0010, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{"br_sub_eq", 2'b01, 3'b101, 1'b1, 64'd5, 64'd5,
                 4'b0110, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{"mem_add", 2'b00, 3'b011, 1'b1, 64'd10, 64'd20,
                 4'b0010, 64'd30, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"r_sub_neg", 2'b10, 3'b000, 1'b1, 64'd7, 64'd9,
                 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"r_and", 2'b10, 3'b111, 1'b0, 64'hF0, 64'h3C,
                 4'b0000, 64'h30, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"r_or", 2'b10, 3'b110, 1'b1, 64'h1, 64'h2,
                 4'b0001, 64'h3, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"r_slt_true", 2'b10, 3'b010, 1'b0, 64'd1, 64'd2,
                 4'b0111, 64'd1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"r_slt_unsigned", 2'b10, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                 4'b0111, 64'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"ill_aluop11", 2'b11, 3'b000, 1'b0, 64'd2, 64'd3,
                 ILL_EN ? 4'b1111 : 4'b0010, ILL_EN ? 64'd0 : 64'd5, 1'b0, ILL_EN, ILL_EN};
    vecs[9]  = '{"ill_slt_f7", 2'b10, 3'b010, 1'b1, 64'd2, 64'd3,
                 ILL_EN ? 4'b1111 : 4'b0010, ILL_EN ? 64'd0 : 64'd5, 1'b0, ILL_EN, ILL_EN};
    vecs[10] = '{"ill_sll", 2'b10, 3'b001, 1'b0, 64'd2, 64'd3,
                 ILL_EN ? 4'b1111 : 4'b0010, ILL_EN ? 64'd0 : 64'd5, 1'b0, ILL_EN, ILL_EN};

    // Power-on reset.
    rst_n = 1'b0;
    #3;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("por_reqready", 64'(reqReady), 64'd1);

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // Backpressure on an AND, with an OR request waiting behind it.
    rspReady = 1'b0;
    v = vecs[4];
    drive_req(v);
    @(posedge clk); #1;
    exp_cnt++;
    v = vecs[5];
    drive_req(v);
    check("bp_ready_issue", 64'(reqReady), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rspvalid_held", 64'(rspValid), 64'd1);
      check("bp_result_held", rspResult, 64'h30);
      check("bp_reqready_low", 64'(reqReady), 64'd0);
      check("bp_count_held", 64'(issueCount), 64'(exp_cnt));
      @(posedge clk); #1;
    end
    rspReady = 1'b1;
    #1;
    check("bp_same_cycle_ready", 64'(reqReady), 64'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    exp_cnt++;
    check("b2b_state_issue", 64'(dbgState), 64'(ISSUE));
    check("b2b_ctrl_or", 64'(ALUControl), 64'(ALU_OR));
    check("b2b_rspvalid_low", 64'(rspValid), 64'd0);
    check("b2b_count", 64'(issueCount), 64'(exp_cnt));
    @(posedge clk); #1;
    check("b2b_rspvalid", 64'(rspValid), 64'd1);
    check("b2b_result", rspResult, 64'h3);
    @(posedge clk); #1;
    check("b2b_idle", 64'(dbgState), 64'(IDLE));

    // Reset asserted while a SLT is in ISSUE.
    v = vecs[6];
    drive_req(v);
    @(posedge clk); #1;
    reqValid = 1'b0;
    check("rst_mid_in_issue", 64'(dbgState), 64'(ISSUE));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    check("rst_mid_no_rsp", 64'(rspValid), 64'd0);
    rst_n = 1'b1;
    exp_cnt = '0;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_mid_rel_ready", 64'(reqReady), 64'd1);
    check("rst_mid_rel_rspvalid", 64'(rspValid), 64'd0);
    check("rst_mid_rel_count", 64'(issueCount), 64'd0);

    // Counter wrap: 17 accepts on a 4-bit counter.
    for (int i = 0; i < 17; i++) run_op(vecs[2]);
    check("cnt_wrap", 64'(issueCount), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front end for the datapath's combinational 64-bit ALU. Accepts decoded-instruction operation requests over a valid/ready handshake, translates ALUOp/funct fields into the 4-bit ALUControl code, drives the ALU operand and control inputs from registers, and captures result and flags into a held response with its own valid/ready handshake. It sits between the control path and the ALU, which is instantiated outside this block.

## Interface
- `WIDTH`, 64: operand and result width.
- `CNT_WIDTH`, 16: width of the issued-operation counter.

- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: asynchronous, active-low reset.
- `reqValid`  input  1: request present.
- `reqReady`  output  1: unit can accept a request this cycle.
- `reqAluOp`  input  2: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- `reqFunct3`  input  3: instruction funct3.
- `reqFunct7b5`  input  1: instruction bit 30.
- `reqA`, `reqB`  input  WIDTH: operands.
- `a`, `b`  output  WIDTH: ALU operands, driven from registers.
- `ALUControl`  output  4: ALU operation, driven from register.
- `result`  input  WIDTH: ALU result.
- `carryOut`, `zero`  input  1: ALU flags.
- `rspValid`  output  1: response held.
- `rspReady`  input  1: consumer takes response.
- `rspResult`  output  WIDTH: captured result.
- `rspCarry`, `rspZero`  output  1: captured flags.
- `rspIllegal`  output  1: decode was illegal. Present only with the macro.
- `issueCount`  output  CNT_WIDTH: number of accepted requests.

## Operation
- Decode:
  - AluOp 00 → 0010 (add).
  - AluOp 01 → 0110 (sub).
  - AluOp 10 with funct3/funct7b5:
    - 000/0 → 0010.
    - 000/1 → 0110.
    - 111/x → 0000 (and).
    - 110/x → 0001 (or).
    - 010/0 → 0111 (slt, unsigned compare).
  - All other combinations are illegal.
- FSM states:
  - IDLE: reqReady=1. Accept moves to ISSUE.
  - ISSUE: reqReady=0. Operands and control are registered onto `a`/`b`/`ALUControl`. The ALU settles this cycle. At the clock edge, result, carryOut and zero are captured into the rsp registers and the state moves to HOLD.
  - HOLD: rspValid=1.
    - rspReady=0: stay in HOLD. All rsp outputs stay stable.
    - rspReady=1 and reqValid=0: go to IDLE.
    - rspReady=1 and reqValid=1: reqReady=1 in the same cycle. The new request is accepted and the state goes to ISSUE (back-to-back).
- An accept is `reqValid && reqReady`. Request fields are sampled only on accept and ignored otherwise.
- `issueCount` increments by 1 on every accept. It wraps from all-ones to 0 with no saturation.
- `a`, `b` and `ALUControl` keep the last issued values after ISSUE. They do not return to zero.

## Timing
- Reset (asynchronous, any state, including mid-ISSUE):
  - State becomes IDLE.
  - reqReady=1 after reset deassertion.
  - rspValid=0; rspResult, rspCarry, rspZero and rspIllegal are 0.
  - `a`=`b`=0, ALUControl=0000, issueCount=0.
  - An in-flight operation is discarded with no response.
- Latency: accept at edge N. ALU driven during cycle N..N+1. rspValid=1 after edge N+1.
- Throughput: one operation per 2 cycles when rspReady is held high.
- rspValid never drops without rspReady=1 at a clock edge.
- The ALU is combinational with no internal registers. The single ISSUE cycle must meet the full ALU path.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined:
  - Illegal decodes drive ALUControl=1111, so the ALU returns 0 and zero=1.
  - `rspIllegal`=1 is captured with the response.
- Not defined:
  - `rspIllegal` port is absent.
  - Illegal decodes map to 0010 (add).
  - The response is otherwise normal.

## Structure
- Package `alu_pkg` holds:
  - ALUControl constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOP=1111.
  - ALUOp constants: ALUOP_MEM, ALUOP_BR, ALUOP_R.
  - FSM state enum: IDLE, ISSUE, HOLD.
- One combinational sub-module, `alu_control_decoder`. Inputs are reqAluOp, reqFunct3 and reqFunct7b5; outputs are ALUControl and illegal. It is reusable by the single-cycle control path.
- The bench instantiates the real ALU connected to `a`, `b`, `ALUControl`, `result`, `carryOut` and `zero`.

## Test plan
- Add with carry: AluOp 10, funct3 000, f7b5 0, A=FFFF_FFFF_FFFF_FFFF, B=1, rspReady=1 → rspValid after edge N+1; rspResult=0, rspCarry=1, rspZero=1; issueCount=1.
- Branch sub: AluOp 01, A=B=5 → ALUControl=0110 during ISSUE; rspResult=0, rspZero=1.
- Backpressure: AND A=F0, B=3C with rspReady=0 for 5 cycles → rspResult=30 held stable, reqReady=0 throughout. Raising rspReady together with reqValid (OR A=1, B=2) → accepted the same cycle; next response rspResult=3.
- Illegal: AluOp 11 → with macro, ALUControl=1111, rspResult=0, rspIllegal=1. Without macro, A=2, B=3 gives rspResult=5.
- Reset during ISSUE (SLT A=1, B=2) → rspValid stays 0, all outputs 0, reqReady=1 after release.
- Counter wrap: CNT_WIDTH=4, 17 accepts → issueCount=1.
